// File: rtl/hamming_secded_stream_decoder.sv
// Streaming Hamming SEC / SECDED decoder for any DATA_W in 4..57.
// Two registered stages (syndrome, then classify/correct) with saturating error counters.
module hamming_secded_stream_decoder #(
  parameter  int DATA_W = 16,
  parameter  int SECDED = 1,
  parameter  int CNT_W  = 16,
  localparam int PAR_W  = (DATA_W <= 4)  ? 3 :
                          (DATA_W <= 11) ? 4 :
                          (DATA_W <= 26) ? 5 : 6,
  localparam int CODE_W = DATA_W + PAR_W + SECDED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sb_err,
  output logic              out_db_err,
  output logic [PAR_W-1:0]  out_syndrome,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  unc_cnt
);

  localparam int N = DATA_W + PAR_W;
  localparam logic [PAR_W:0] N_MAX = (PAR_W + 1)'(N);

  function automatic logic [DATA_W-1:0] extract(input logic [N-1:0] c);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 0; i < N; i++) begin
      // non-power-of-two positions carry data, in ascending order
      if ((((i + 1) & i) != 0) && (j < DATA_W)) begin
        d[j] = c[i];
        j++;
      end
    end
    return d;
  endfunction

  logic             s1_valid_q;
  logic [N-1:0]     s1_code_q;
  logic [PAR_W-1:0] s1_syn_q;
  logic             s1_ovp_q;
  logic [PAR_W-1:0] syn_d;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_sb_q;
  logic              out_db_q;
  logic [PAR_W-1:0]  out_syn_q;

  logic [CNT_W-1:0] corr_q, corr_d;
  logic [CNT_W-1:0] unc_q, unc_d;

  logic out_free, s1_free, fire;

  assign out_free = !out_valid_q || out_ready;
  assign s1_free  = !s1_valid_q || out_free;
  assign in_ready = rst_n && s1_free;
  assign fire     = out_valid_q && out_ready;

  always_comb begin
    syn_d = '0;
    for (int i = 0; i < N; i++) begin
      if (in_code[i]) syn_d = syn_d ^ PAR_W'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_ovp_q   <= 1'b0;
    end else if (s1_free) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_code_q <= in_code[N-1:0];
        s1_syn_q  <= syn_d;
        s1_ovp_q  <= ^in_code;
      end
    end
  end

  logic              syn_zero, in_range, flip;
  logic              sb_d, db_d;
  logic [N-1:0]      fix_code;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    syn_zero = (s1_syn_q == '0);
    in_range = !syn_zero && ({1'b0, s1_syn_q} <= N_MAX);
    sb_d = 1'b0;
    db_d = 1'b0;
    flip = 1'b0;
    if (SECDED != 0) begin
      unique case (1'b1)
        (!s1_ovp_q && syn_zero): ;
        (s1_ovp_q && syn_zero):  sb_d = 1'b1;
        (s1_ovp_q && in_range): begin
          sb_d = 1'b1;
          flip = 1'b1;
        end
        (s1_ovp_q && !syn_zero && !in_range): db_d = 1'b1;
        default: db_d = 1'b1;
      endcase
    end else begin
      unique case (1'b1)
        syn_zero: ;
        in_range: begin
          sb_d = 1'b1;
          flip = 1'b1;
        end
        default: db_d = 1'b1;
      endcase
    end
    fix_code = s1_code_q;
    for (int i = 0; i < N; i++) begin
      if (flip && (s1_syn_q == PAR_W'(i + 1))) fix_code[i] = ~s1_code_q[i];
    end
    data_d = extract(fix_code);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sb_q    <= 1'b0;
      out_db_q    <= 1'b0;
      out_syn_q   <= '0;
    end else if (out_free) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= data_d;
        out_sb_q   <= sb_d;
        out_db_q   <= db_d;
        out_syn_q  <= s1_syn_q;
      end
    end
  end

  always_comb begin
    corr_d = corr_q;
    unc_d  = unc_q;
    if (clr_cnt) begin
      corr_d = '0;
      unc_d  = '0;
    end else begin
      if (fire && out_sb_q && (corr_q != '1)) corr_d = corr_q + CNT_W'(1);
      if (fire && out_db_q && (unc_q != '1))  unc_d  = unc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      corr_q <= '0;
      unc_q  <= '0;
    end else begin
      corr_q <= corr_d;
      unc_q  <= unc_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_sb_err   = out_sb_q;
  assign out_db_err   = out_db_q;
  assign out_syndrome = out_syn_q;
  assign corr_cnt     = corr_q;
  assign unc_cnt      = unc_q;

endmodule
